// File: rtl/systolic_mm_engine.sv
// Output-stationary ROWS x COLS systolic matrix-multiply engine.
// Operands stream in with internal skew; results drain one accumulator row per handshake.
//   state | meaning
//   IDLE  | waiting for start, results retained
//   LOAD  | accepting operand beats, array advances on in_valid
//   FLUSH | injecting zeros for ROWS+COLS-1 cycles
//   DRAIN | presenting accumulator rows on out_row
module systolic_mm_engine #(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int K_MAX      = 256,
  parameter int KW         = $clog2(K_MAX+1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [KW-1:0]                 k_len,
  input  logic                          acc_clear,
  input  logic                          is_signed,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]    in_row,
  input  logic [COLS*DATA_WIDTH-1:0]    in_col,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [COLS*ACC_WIDTH-1:0]     out_row,
  output logic [$clog2(ROWS)-1:0]       out_row_idx,
  output logic                          busy,
  output logic                          done
);

  localparam int RW = $clog2(ROWS);
  localparam int FW = $clog2(ROWS+COLS);
  localparam int DW = DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   cnt_q, cnt_d, klen_q, klen_d;
  logic [FW-1:0]   fl_q, fl_d;
  logic [RW-1:0]   idx_q, idx_d;
  logic            sgn_q, sgn_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            adv, clr;

  logic [DW-1:0]        a_chain [ROWS][ROWS];
  logic [DW-1:0]        b_chain [COLS][COLS];
  logic [DW-1:0]        ska_q [ROWS][ROWS-1];
  logic [DW-1:0]        ska_d [ROWS][ROWS-1];
  logic [DW-1:0]        skb_q [COLS][COLS-1];
  logic [DW-1:0]        skb_d [COLS][COLS-1];
  logic [DW-1:0]        a_q   [ROWS][COLS];
  logic [DW-1:0]        a_d   [ROWS][COLS];
  logic [DW-1:0]        b_q   [ROWS][COLS];
  logic [DW-1:0]        b_d   [ROWS][COLS];
  logic [ACC_WIDTH-1:0] acc_q [ROWS][COLS];
  logic [ACC_WIDTH-1:0] acc_d [ROWS][COLS];

  // One extra sign bit per operand lets a single signed multiplier serve both modes.
  function automatic logic [ACC_WIDTH-1:0] mac_prod(input logic [DW-1:0] a,
                                                    input logic [DW-1:0] b,
                                                    input logic sgn);
    logic signed [DW:0]     ea;
    logic signed [DW:0]     eb;
    logic signed [2*DW+1:0] p;
    ea = $signed({sgn & a[DW-1], a});
    eb = $signed({sgn & b[DW-1], b});
    p  = (2*DW+2)'(ea) * (2*DW+2)'(eb);
    return ACC_WIDTH'(p);
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    klen_d      = klen_q;
    fl_d        = fl_q;
    idx_d       = idx_q;
    sgn_d       = sgn_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    adv         = 1'b0;
    clr         = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          klen_d = k_len;
          sgn_d  = is_signed;
          clr    = acc_clear;
          cnt_d  = '0;
          idx_d  = '0;
          busy_d = 1'b1;
          if (k_len != '0) begin
            state_d    = LOAD;
            in_ready_d = 1'b1;
          end else begin
            state_d     = DRAIN;
            out_valid_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (in_valid) begin
          adv   = 1'b1;
          cnt_d = cnt_q + KW'(1);
          if (cnt_q == klen_q - KW'(1)) begin
            state_d    = FLUSH;
            in_ready_d = 1'b0;
            fl_d       = '0;
          end
        end
      end
      FLUSH: begin
        adv  = 1'b1;
        fl_d = fl_q + FW'(1);
        if (fl_q == FW'(ROWS+COLS-2)) begin
          state_d     = DRAIN;
          out_valid_d = 1'b1;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (idx_q == RW'(ROWS-1)) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            idx_d       = '0;
          end else begin
            idx_d = idx_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Tap s of a chain is the operand delayed by s advances; tap 0 is the live input.
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      a_chain[i][0] = (state_q == LOAD) ? in_row[i*DW +: DW] : '0;
      for (int s = 1; s < ROWS; s++) a_chain[i][s] = ska_q[i][s-1];
    end
    for (int j = 0; j < COLS; j++) begin
      b_chain[j][0] = (state_q == LOAD) ? in_col[j*DW +: DW] : '0;
      for (int s = 1; s < COLS; s++) b_chain[j][s] = skb_q[j][s-1];
    end
    ska_d = ska_q;
    skb_d = skb_q;
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    if (adv) begin
      for (int i = 0; i < ROWS; i++)
        for (int s = 0; s < ROWS-1; s++) ska_d[i][s] = a_chain[i][s];
      for (int j = 0; j < COLS; j++)
        for (int s = 0; s < COLS-1; s++) skb_d[j][s] = b_chain[j][s];
      for (int i = 0; i < ROWS; i++) begin
        a_d[i][0] = a_chain[i][i];
        for (int j = 1; j < COLS; j++) a_d[i][j] = a_q[i][j-1];
      end
      for (int j = 0; j < COLS; j++) begin
        b_d[0][j] = b_chain[j][j];
        for (int i = 1; i < ROWS; i++) b_d[i][j] = b_q[i-1][j];
      end
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          acc_d[i][j] = acc_q[i][j] + mac_prod(a_q[i][j], b_q[i][j], sgn_q);
    end
    if (clr) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) acc_d[i][j] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      klen_q      <= '0;
      fl_q        <= '0;
      idx_q       <= '0;
      sgn_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < ROWS; i++)
        for (int s = 0; s < ROWS-1; s++) ska_q[i][s] <= '0;
      for (int j = 0; j < COLS; j++)
        for (int s = 0; s < COLS-1; s++) skb_q[j][s] <= '0;
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) begin
          a_q[i][j]   <= '0;
          b_q[i][j]   <= '0;
          acc_q[i][j] <= '0;
        end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      klen_q      <= klen_d;
      fl_q        <= fl_d;
      idx_q       <= idx_d;
      sgn_q       <= sgn_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ska_q       <= ska_d;
      skb_q       <= skb_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
    end
  end

  always_comb begin
    out_row = '0;
    for (int j = 0; j < COLS; j++)
      out_row[j*ACC_WIDTH +: ACC_WIDTH] = out_valid_q ? acc_q[idx_q][j] : '0;
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_row_idx = idx_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed bench for systolic_mm_engine: a 4x4/32-bit array plus a 2x2/16-bit array for wrap.
module tb_systolic_mm_engine;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, acc_clear = 1'b0, is_signed = 1'b0;
  logic [8:0]    k_len = '0;
  logic          in_valid = 1'b0, out_ready = 1'b0;
  logic          in_ready, out_valid, busy, done;
  logic [R*8-1:0]  in_row = '0;
  logic [C*8-1:0]  in_col = '0;
  logic [C*AW-1:0] out_row;
  logic [1:0]      out_row_idx;

  logic          s_start = 1'b0, s_acc_clear = 1'b0, s_is_signed = 1'b0;
  logic [8:0]    s_k_len = '0;
  logic          s_in_valid = 1'b0, s_out_ready = 1'b0;
  logic          s_in_ready, s_out_valid, s_busy, s_done;
  logic [15:0]   s_in_row = '0, s_in_col = '0;
  logic [31:0]   s_out_row;
  logic [0:0]    s_out_row_idx;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0]  ta    [R][16];
  logic [7:0]  tbm   [16][C];
  logic [31:0] exp_c [R][C];

  always #5 clk = ~clk;

  systolic_mm_engine #(.ROWS(R), .COLS(C), .DATA_WIDTH(8), .ACC_WIDTH(AW), .K_MAX(256)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .acc_clear(acc_clear),
    .is_signed(is_signed), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .in_col(in_col), .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_row_idx(out_row_idx), .busy(busy), .done(done));

  systolic_mm_engine #(.ROWS(2), .COLS(2), .DATA_WIDTH(8), .ACC_WIDTH(16), .K_MAX(256)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .k_len(s_k_len), .acc_clear(s_acc_clear),
    .is_signed(s_is_signed), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_row(s_in_row),
    .in_col(s_in_col), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_row(s_out_row),
    .out_row_idx(s_out_row_idx), .busy(s_busy), .done(s_done));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic fill_const(input logic [7:0] a, input logic [7:0] b, input logic [31:0] e);
    for (int i = 0; i < R; i++) for (int k = 0; k < 16; k++) ta[i][k] = a;
    for (int k = 0; k < 16; k++) for (int j = 0; j < C; j++) tbm[k][j] = b;
    for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) exp_c[i][j] = e;
  endtask

  // A = identity, B row k = {4k+1 .. 4k+4}, so C = B.
  task automatic fill_ident();
    for (int i = 0; i < R; i++) for (int k = 0; k < 16; k++) ta[i][k] = (i == k) ? 8'd1 : 8'd0;
    for (int k = 0; k < 16; k++) for (int j = 0; j < C; j++) tbm[k][j] = 8'(4*k + j + 1);
    for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) exp_c[i][j] = 32'(4*i + j + 1);
  endtask

  task automatic start_tile(input int k, input logic clr, input logic sgn);
    start = 1'b1; k_len = 9'(k); acc_clear = clr; is_signed = sgn;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beats(input int k, input bit stall);
    for (int b = 0; b < k; b++) begin
      in_valid = 1'b1;
      for (int i = 0; i < R; i++) in_row[i*8 +: 8] = ta[i][b];
      for (int j = 0; j < C; j++) in_col[j*8 +: 8] = tbm[b][j];
      check_eq("in_ready", {63'd0, in_ready}, 64'd1);
      @(negedge clk);
      if (stall && b < k-1) begin
        in_valid = 1'b0;
        in_row = {R{8'hEE}};
        in_col = {C{8'hEE}};
        repeat (2) @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic check_row(input int r);
    check_eq("row_idx", {62'd0, out_row_idx}, 64'(r));
    for (int j = 0; j < C; j++)
      check_eq($sformatf("c[%0d][%0d]", r, j), {32'd0, out_row[j*AW +: AW]}, {32'd0, exp_c[r][j]});
  endtask

  task automatic drain(input int stall);
    int w = 0;
    while (!out_valid && w < 100) begin @(negedge clk); w++; end
    check_eq("drain_valid", {63'd0, out_valid}, 64'd1);
    for (int r = 0; r < R; r++) begin
      for (int s = 0; s < stall; s++) begin
        out_ready = 1'b0;
        check_row(r);
        @(negedge clk);
      end
      check_row(r);
      check_eq("done_early", {63'd0, done}, 64'd0);
      out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    check_eq("done_pulse", {63'd0, done}, 64'd1);
    check_eq("valid_drop", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    check_eq("done_clear", {63'd0, done}, 64'd0);
    check_eq("busy_idle", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int lat;
    int w;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_out_row", out_row[63:0], 64'd0);
    check_eq("rst_idx", {62'd0, out_row_idx}, 64'd0);

    // identity x B, with first-valid latency
    fill_ident();
    start_tile(4, 1'b1, 1'b0);
    check_eq("busy_load", {63'd0, busy}, 64'd1);
    send_beats(4, 1'b0);
    lat = 1;
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    check_eq("latency", 64'(lat), 64'd8);
    drain(0);

    // signed and unsigned all-ones-byte operands
    fill_const(8'hFF, 8'hFF, 32'd3);
    start_tile(3, 1'b1, 1'b1); send_beats(3, 1'b0); drain(0);
    fill_const(8'hFF, 8'hFF, 32'd195075);
    start_tile(3, 1'b1, 1'b0); send_beats(3, 1'b0); drain(0);

    // accumulate across tiles
    fill_const(8'd1, 8'd1, 32'd2);
    start_tile(2, 1'b1, 1'b0); send_beats(2, 1'b0); drain(0);
    fill_const(8'd1, 8'd1, 32'd4);
    start_tile(2, 1'b0, 1'b0); send_beats(2, 1'b0); drain(0);

    // input stalls and output backpressure
    fill_ident();
    start_tile(4, 1'b1, 1'b0); send_beats(4, 1'b1); drain(5);

    // k_len = 0 and start during DRAIN
    fill_const(8'd0, 8'd0, 32'd0);
    start_tile(0, 1'b1, 1'b0);
    check_eq("k0_valid", {63'd0, out_valid}, 64'd1);
    start = 1'b1; k_len = 9'd3; acc_clear = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("drain_start_in_ready", {63'd0, in_ready}, 64'd0);
    check_eq("drain_start_valid", {63'd0, out_valid}, 64'd1);
    check_eq("drain_start_idx", {62'd0, out_row_idx}, 64'd0);
    drain(0);
    check_eq("post_drain_in_ready", {63'd0, in_ready}, 64'd0);

    // reset mid-LOAD, then a fresh accumulate-on tile
    fill_const(8'h10, 8'h10, 32'd0);
    start_tile(4, 1'b1, 1'b0);
    in_valid = 1'b1;
    in_row = {R{8'h10}};
    in_col = {C{8'h10}};
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_busy", {63'd0, busy}, 64'd0);
    check_eq("abort_in_ready", {63'd0, in_ready}, 64'd0);
    check_eq("abort_done", {63'd0, done}, 64'd0);
    fill_ident();
    start_tile(4, 1'b0, 1'b0); send_beats(4, 1'b0); drain(0);

    // 16-bit accumulator wrap on the 2x2 instance
    s_start = 1'b1; s_k_len = 9'd2; s_acc_clear = 1'b1; s_is_signed = 1'b0;
    @(negedge clk);
    s_start = 1'b0;
    s_in_valid = 1'b1; s_in_row = 16'hFFFF; s_in_col = 16'hFFFF;
    repeat (2) @(negedge clk);
    s_in_valid = 1'b0;
    w = 0;
    while (!s_out_valid && w < 50) begin @(negedge clk); w++; end
    check_eq("s_valid", {63'd0, s_out_valid}, 64'd1);
    s_out_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      check_eq("s_idx", {63'd0, s_out_row_idx}, 64'(r));
      check_eq("s_c0", {48'd0, s_out_row[15:0]}, 64'd64514);
      check_eq("s_c1", {48'd0, s_out_row[31:16]}, 64'd64514);
      @(negedge clk);
    end
    s_out_ready = 1'b0;
    check_eq("s_done", {63'd0, s_done}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/systolic_mm_engine.md
Name: systolic_mm_engine

Overview:
- Output-stationary ROWS x COLS systolic matrix-multiply engine with handshaked operand streaming and result draining.
- Computes C[i][j] = sum over k of A[i][k]*B[k][j], where k runs 0..k_len-1.
- Internal input skewing, an array-wide stall, and signed/unsigned mode are built in; accumulators can either clear or carry over between tiles.
- Sits between the operand buffers and the output/activation stage, and replaces the fixed square array wrapper.

Parameters:
- ROWS, 8, number of PE rows (A operands per beat)
- COLS, 8, number of PE columns (B operands per beat)
- DATA_WIDTH, 8, operand width
- ACC_WIDTH, 32, accumulator width; must be >= 2*DATA_WIDTH
- K_MAX, 256, maximum reduction length
- KW, $clog2(K_MAX+1), width of k_len (derived)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  tile start pulse; only honoured in IDLE
- k_len  in  KW  reduction length, sampled with start
- acc_clear  in  1  sampled with start; 1 = zero accumulators, 0 = accumulate onto previous tile results
- is_signed  in  1  sampled with start; 1 = two's-complement operands
- in_valid  in  1  operand beat valid
- in_ready  out  1  operand beat accepted when in_valid & in_ready
- in_row  in  ROWS*DATA_WIDTH  A column k; element i in bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_col  in  COLS*DATA_WIDTH  B row k; element j in bits [j*DATA_WIDTH +: DATA_WIDTH]
- out_valid  out  1  result row valid
- out_ready  in  1  result row accepted when out_valid & out_ready
- out_row  out  COLS*ACC_WIDTH  C row out_row_idx; element j in bits [j*ACC_WIDTH +: ACC_WIDTH]
- out_row_idx  out  $clog2(ROWS)  index of the presented row
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last row is accepted

Behaviour:
- Reset: state IDLE. All accumulators, skew registers, PE operand registers and beat counters are zeroed. in_ready, out_valid, busy and done are 0; out_row and out_row_idx are 0. Reset takes effect in any state, including mid-LOAD and mid-DRAIN; in-flight data is discarded and no done pulse is issued.

State machine:
- IDLE: start=1 latches k_len, acc_clear and is_signed. If acc_clear=1, all accumulators are zeroed on that edge. Next state is LOAD if k_len>0, otherwise DRAIN.
- LOAD: in_ready=1. Each accepted beat enters the skew network and advances the array one step, and the beat counter increments. A cycle with in_valid=0 freezes the whole array: skew registers, PE registers and accumulators all hold. After beat k_len is accepted, next state is FLUSH.
- FLUSH: in_ready=0. Zeros are injected for exactly ROWS+COLS-1 cycles with the array advancing unconditionally; the next state is DRAIN. On entering DRAIN every accumulator holds its final value.
- DRAIN: out_valid=1, out_row = accumulator row out_row_idx, and out_row_idx starts at 0. out_row and out_row_idx stay stable while out_valid & ~out_ready. Each accepted row increments out_row_idx. When row ROWS-1 is accepted: done=1 for one cycle, next state IDLE, out_valid drops in the same cycle as done.
- start is ignored outside IDLE. An in_valid outside LOAD is not consumed.

Skew and datapath:
- Row i of A is delayed by i stages before PE(i,0); column j of B is delayed by j stages before PE(0,j).
- A passes right and B passes down, one register stage per PE per advance.
- Each advance, every PE computes acc <= acc + ext(a)*ext(b). ext() sign-extends when is_signed=1 and zero-extends otherwise. The product is 2*DATA_WIDTH bits, extended to ACC_WIDTH.
- Accumulation wraps modulo 2^ACC_WIDTH; there is no saturation and no overflow flag.
- Timing: latency from the final LOAD beat to the first out_valid is ROWS+COLS cycles. Throughput in LOAD is one beat per cycle.
- Results are retained in IDLE, so acc_clear=0 on the next start accumulates onto them.

Test Plan:
- ROWS=COLS=4, DATA_WIDTH=8, k_len=4, acc_clear=1, A=identity, B rows = {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16} -> drained rows equal B; out_row_idx 0..3; done pulses once; first out_valid exactly 8 cycles after the last beat.
- Signed: is_signed=1, k_len=3, all A=8'hFF, all B=8'hFF -> every C = 3. Same data with is_signed=0 -> every C = 3*65025 = 195075.
- Accumulate: tile 1 with A=B=all 1, k_len=2, acc_clear=1 -> all C = 2. Tile 2 with the same data, acc_clear=0 -> all C = 4.
- Stalls and backpressure: in_valid toggled 1,0,0,1,... in LOAD and out_ready held low for 5 cycles per row in DRAIN -> results identical to the unstalled run; out_row stable while stalled.
- Boundaries: k_len=0 with acc_clear=1 -> DRAIN immediately, all zeros. ACC_WIDTH=16, unsigned, A=B=8'hFF, k_len=2 -> C = 130050 mod 65536 = 64514. start asserted during DRAIN -> ignored.
- Reset mid-LOAD after 2 of 4 beats -> next cycle: IDLE, busy=0, in_ready=0. A fresh tile with acc_clear=0 gives results containing no contribution from the aborted beats.
